// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_ctrl
//  Description : Producer-side instruction sequencer for the 8-bit ALU.
//                Accepts 16-bit instruction words on a valid/ready handshake,
//                reads operands from an internal 8x8 register file, drives
//                the combinational ALU, captures its result and flags, then
//                writes back and updates the architectural flag register.
//                One instruction at a time: IDLE -> EXEC -> WB -> IDLE.
//
//  Ports       : clock_i/reset_i        clock, synchronous active-high reset
//                instr_valid_i/ready_o  instruction handshake
//                instr_i                [15:11] op [10:8] rd [7:5] rs [4:2] im
//                rf_wr_*_i              external register load (IDLE only)
//                alu_*_o / alu_*_i      ALU operand drive / result capture
//                flags_o                architectural {CF,ZF,SF,OF}
//                done_o/illegal_o       retire pulse / undefined-opcode pulse
//                show_valid_o/data_o    SHOWR retire pulse / held value
//                dbg_addr_i/dbg_data_o  combinational register read port
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
    parameter int         RF_DEPTH    = 8,
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    input  logic [15:0] instr_i,
    input  logic        rf_wr_en_i,
    input  logic [2:0]  rf_wr_addr_i,
    input  logic [7:0]  rf_wr_data_i,
    output logic [4:0]  alu_op_o,
    output logic [7:0]  alu_in1_o,
    output logic [7:0]  alu_in2_o,
    output logic [2:0]  alu_im_o,
    input  logic [7:0]  alu_res_i,
    input  logic        alu_cf_i,
    input  logic        alu_zf_i,
    input  logic        alu_sf_i,
    input  logic        alu_of_i,
    output logic [3:0]  flags_o,
    output logic        done_o,
    output logic        illegal_o,
    output logic        show_valid_o,
    output logic [7:0]  show_data_o,
    input  logic [2:0]  dbg_addr_i,
    output logic [7:0]  dbg_data_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    localparam logic [4:0] c_OP_NOP   = 5'b00000;
    localparam logic [4:0] c_OP_MOV   = 5'b00110;
    localparam logic [4:0] c_OP_NOT   = 5'b01000;
    localparam logic [4:0] c_OP_SHOWR = 5'b11111;

    state_t      state_q, state_d;
    logic [7:0]  rf_q [RF_DEPTH];
    logic [2:0]  rd_q;
    logic [4:0]  alu_op_q;
    logic [7:0]  alu_in1_q;
    logic [7:0]  alu_in2_q;
    logic [2:0]  alu_im_q;
    logic [7:0]  res_q;
    logic [3:0]  res_flags_q;
    logic [3:0]  flags_q;
    logic [7:0]  show_data_q;

    logic        w_accept;
    logic        w_load;
    logic        w_wb_rf;
    logic        w_wb_flags;
    logic        w_unused_rsvd;

    // Reserved instruction bits carry no meaning.
    assign w_unused_rsvd = ^instr_i[1:0];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        instr_ready_o = 1'b0;
        done_o        = 1'b0;
        illegal_o     = 1'b0;
        show_valid_o  = 1'b0;
        w_accept      = 1'b0;
        w_load        = 1'b0;
        w_wb_rf       = 1'b0;
        w_wb_flags    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // An external load takes the whole IDLE cycle; the pending
                // instruction waits for a cycle without a load.
                instr_ready_o = !rf_wr_en_i;
                w_load        = rf_wr_en_i;
                if (!rf_wr_en_i && instr_valid_i) begin
                    w_accept = 1'b1;
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_WB;
            end
            S_WB: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
                if (alu_op_q inside {[5'd1:5'd5], [5'd9:5'd14]}) begin
                    w_wb_rf    = 1'b1;
                    w_wb_flags = 1'b1;
                end else if (alu_op_q == c_OP_MOV || alu_op_q == c_OP_NOT) begin
                    w_wb_rf = 1'b1;
                end else if (alu_op_q == c_OP_SHOWR) begin
                    show_valid_o = 1'b1;
                end else if (alu_op_q != c_OP_NOP) begin
                    illegal_o = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand capture, result capture, commit
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                rf_q[i] <= 8'h00;
            end
            rd_q        <= 3'd0;
            alu_op_q    <= 5'd0;
            alu_in1_q   <= 8'h00;
            alu_in2_q   <= 8'h00;
            alu_im_q    <= 3'd0;
            res_q       <= 8'h00;
            res_flags_q <= 4'b0000;
            flags_q     <= RESET_FLAGS;
            show_data_q <= 8'h00;
        end else begin
            if (w_load) begin
                rf_q[rf_wr_addr_i] <= rf_wr_data_i;
            end
            // Operands are read at accept so a later writeback to rd can
            // never alias the values the ALU is working on.
            if (w_accept) begin
                alu_op_q  <= instr_i[15:11];
                rd_q      <= instr_i[10:8];
                alu_in1_q <= rf_q[instr_i[10:8]];
                alu_in2_q <= rf_q[instr_i[7:5]];
                alu_im_q  <= instr_i[4:2];
            end
            if (state_q == S_EXEC) begin
                res_q       <= alu_res_i;
                res_flags_q <= {alu_cf_i, alu_zf_i, alu_sf_i, alu_of_i};
            end
            if (w_wb_rf) begin
                rf_q[rd_q] <= res_q;
            end
            if (w_wb_flags) begin
                flags_q <= res_flags_q;
            end
            if (show_valid_o) begin
                show_data_q <= res_q;
            end
        end
    end

    assign alu_op_o    = alu_op_q;
    assign alu_in1_o   = alu_in1_q;
    assign alu_in2_o   = alu_in2_q;
    assign alu_im_o    = alu_im_q;
    assign flags_o     = flags_q;
    assign show_data_o = show_data_q;
    assign dbg_data_o  = rf_q[dbg_addr_i];

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
//  Module      : tb_alu_issue_ctrl
//  Description : Self-checking bench for alu_issue_ctrl. A behavioural ALU
//                stub answers the DUT's operand drive; a register-file /
//                flag model predicts every retire.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = 16'h0000;
    logic        rf_wr_en = 1'b0;
    logic [2:0]  rf_wr_addr = 3'd0;
    logic [7:0]  rf_wr_data = 8'h00;
    logic [4:0]  alu_op;
    logic [7:0]  alu_in1, alu_in2;
    logic [2:0]  alu_im;
    logic [7:0]  alu_res;
    logic        alu_cf, alu_zf, alu_sf, alu_of;
    logic [3:0]  flags;
    logic        done, illegal, show_valid;
    logic [7:0]  show_data;
    logic [2:0]  dbg_addr = 3'd0;
    logic [7:0]  dbg_data;

    localparam logic [3:0] c_RESET_FLAGS = 4'b0000;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.RF_DEPTH(8), .RESET_FLAGS(c_RESET_FLAGS)) dut (
        .clock_i(clk), .reset_i(rst),
        .instr_valid_i(instr_valid), .instr_ready_o(instr_ready), .instr_i(instr),
        .rf_wr_en_i(rf_wr_en), .rf_wr_addr_i(rf_wr_addr), .rf_wr_data_i(rf_wr_data),
        .alu_op_o(alu_op), .alu_in1_o(alu_in1), .alu_in2_o(alu_in2), .alu_im_o(alu_im),
        .alu_res_i(alu_res), .alu_cf_i(alu_cf), .alu_zf_i(alu_zf),
        .alu_sf_i(alu_sf), .alu_of_i(alu_of),
        .flags_o(flags), .done_o(done), .illegal_o(illegal),
        .show_valid_o(show_valid), .show_data_o(show_data),
        .dbg_addr_i(dbg_addr), .dbg_data_o(dbg_data)
    );

    // ALU stub: returns {res, CF, ZF, SF, OF}.
    function automatic logic [11:0] alu_fn(input logic [4:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic [2:0] im);
        logic [8:0] s;
        logic [7:0] r;
        logic       cf, of;
        cf = 1'b0;
        of = 1'b0;
        case (op)
            5'd0:  return {8'h00, 4'b1111};
            5'd1: begin
                s  = {1'b0, a} + {1'b0, b};
                r  = s[7:0];
                cf = s[8];
                of = (a[7] == b[7]) && (r[7] != a[7]);
            end
            5'd2: begin
                r  = a - b;
                cf = (a < b);
                of = (a[7] != b[7]) && (r[7] != a[7]);
            end
            5'd3:  r = a & b;
            5'd6:  r = b;
            5'd8:  r = ~a;
            5'd31: r = a;
            default: begin
                r  = (a ^ {b[4:0], b[7:5]}) + {5'b0, im};
                cf = a[0] ^ b[1];
                of = im[0];
            end
        endcase
        return {r, cf, (r == 8'h00), r[7], of};
    endfunction

    assign {alu_res, alu_cf, alu_zf, alu_sf, alu_of} = alu_fn(alu_op, alu_in1, alu_in2, alu_im);

    // Reference model
    logic [7:0] m_rf [8];
    logic [3:0] m_flags;
    logic [7:0] m_show;
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
        m_flags = c_RESET_FLAGS;
        m_show  = 8'h00;
    endtask

    // Full architectural state comparison through the debug port.
    task automatic check_state(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #0.4;
            chk($sformatf("%s_r%0d", tag, i), {24'h0, dbg_data}, {24'h0, m_rf[i]});
        end
        chk({tag, "_flags"}, {28'h0, flags}, {28'h0, m_flags});
        chk({tag, "_show"}, {24'h0, show_data}, {24'h0, m_show});
    endtask

    task automatic load(input logic [2:0] a, input logic [7:0] d);
        rf_wr_en   = 1'b1;
        rf_wr_addr = a;
        rf_wr_data = d;
        #0.1;
        chk("load_ready_low", {31'h0, instr_ready}, 32'd0);
        tick();
        rf_wr_en = 1'b0;
        m_rf[a]  = d;
    endtask

    // 0 nop, 1 arith, 2 move, 3 show, 4 illegal
    function automatic int op_kind(input logic [4:0] op);
        if (op == 5'd0) return 0;
        if (op == 5'd31) return 3;
        if (op == 5'd6 || op == 5'd8) return 2;
        if ((op >= 5'd1 && op <= 5'd5) || (op >= 5'd9 && op <= 5'd14)) return 1;
        return 4;
    endfunction

    task automatic issue(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs,
                         input logic [2:0] im, input bit noise);
        logic [11:0] r;
        int          k;
        r = alu_fn(op, m_rf[rd], m_rf[rs], im);
        k = op_kind(op);
        instr       = {op, rd, rs, im, 2'($urandom)};
        instr_valid = 1'b1;
        #0.1;
        chk("idle_ready", {31'h0, instr_ready}, 32'd1);
        tick();                               // accept edge: now EXEC
        instr_valid = 1'b0;
        if (noise) begin
            // Traffic that must be ignored while busy.
            instr_valid = 1'b1;
            instr       = 16'($urandom);
            rf_wr_en    = 1'b1;
            rf_wr_addr  = rd;
            rf_wr_data  = ~r[11:4];
        end
        chk("exec_ready", {31'h0, instr_ready}, 32'd0);
        chk("exec_done", {31'h0, done}, 32'd0);
        chk("exec_op", {27'h0, alu_op}, {27'h0, op});
        chk("exec_in1", {24'h0, alu_in1}, {24'h0, m_rf[rd]});
        chk("exec_in2", {24'h0, alu_in2}, {24'h0, m_rf[rs]});
        chk("exec_im", {29'h0, alu_im}, {29'h0, im});
        tick();                               // WB
        instr_valid = 1'b0;
        rf_wr_en    = 1'b0;
        chk("wb_done", {31'h0, done}, 32'd1);
        chk("wb_ready", {31'h0, instr_ready}, 32'd0);
        chk("wb_illegal", {31'h0, illegal}, {31'h0, (k == 4)});
        chk("wb_show", {31'h0, show_valid}, {31'h0, (k == 3)});
        tick();                               // back in IDLE, commit visible
        if (k == 1 || k == 2) m_rf[rd] = r[11:4];
        if (k == 1) m_flags = r[3:0];
        if (k == 3) m_show = r[11:4];
        chk("post_done", {31'h0, done}, 32'd0);
        chk("post_ready", {31'h0, instr_ready}, 32'd1);
        check_state("post");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        tick();
        tick();
        rst = 1'b0;
        // Reset state
        chk("rst_ready", {31'h0, instr_ready}, 32'd1);
        chk("rst_done", {31'h0, done}, 32'd0);
        chk("rst_alu_op", {27'h0, alu_op}, 32'd0);
        chk("rst_alu_in1", {24'h0, alu_in1}, 32'd0);
        check_state("rst");

        // ADD 0x7F + 0x01
        load(3'd1, 8'h7F);
        load(3'd2, 8'h01);
        issue(5'd1, 3'd1, 3'd2, 3'd0, 1'b0);
        chk("add_r1", {24'h0, m_rf[1]}, 32'h80);
        chk("add_flags", {28'h0, flags}, 32'b0011);

        // AND to zero
        load(3'd3, 8'hF0);
        load(3'd4, 8'h0F);
        issue(5'd3, 3'd3, 3'd4, 3'd0, 1'b0);
        chk("and_flags", {28'h0, flags}, 32'b0100);

        // MOV keeps flags
        issue(5'd6, 3'd5, 3'd1, 3'd0, 1'b0);
        chk("mov_flags", {28'h0, flags}, 32'b0100);
        chk("mov_r5", {24'h0, m_rf[5]}, 32'h80);

        // SHOWR, illegal, NOP
        issue(5'd31, 3'd5, 3'd0, 3'd0, 1'b0);
        chk("show_data", {24'h0, show_data}, 32'h80);
        issue(5'd16, 3'd2, 3'd3, 3'd1, 1'b0);
        issue(5'd0, 3'd2, 3'd3, 3'd1, 1'b0);

        // Load and valid together: load wins, instruction next cycle
        instr       = {5'd1, 3'd6, 3'd6, 3'd0, 2'b00};
        instr_valid = 1'b1;
        rf_wr_en    = 1'b1;
        rf_wr_addr  = 3'd6;
        rf_wr_data  = 8'h33;
        #0.1;
        chk("ld_valid_ready", {31'h0, instr_ready}, 32'd0);
        tick();
        rf_wr_en = 1'b0;
        m_rf[6]  = 8'h33;
        #0.1;
        chk("ld_valid_still_idle", {31'h0, instr_ready}, 32'd1);
        issue(5'd1, 3'd6, 3'd6, 3'd0, 1'b0);
        chk("ld_valid_r6", {24'h0, m_rf[6]}, 32'h66);

        // Busy-time traffic is ignored
        issue(5'd2, 3'd1, 3'd6, 3'd2, 1'b1);

        // Reset during EXEC aborts
        instr       = {5'd1, 3'd1, 3'd1, 3'd0, 2'b00};
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        rst         = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        chk("abort_done", {31'h0, done}, 32'd0);
        chk("abort_ready", {31'h0, instr_ready}, 32'd1);
        chk("abort_alu_op", {27'h0, alu_op}, 32'd0);
        check_state("abort");
        tick();
        chk("abort_done2", {31'h0, done}, 32'd0);
        check_state("abort2");

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                load(3'($urandom), 8'($urandom));
            end else begin
                issue(5'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                      1'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Instruction sequencer on the producer side of the 8-bit ALU.
- Accepts 16-bit instruction words over a valid/ready handshake and reads operands from an internal 8x8 register file.
- Drives the ALU's op/in1/in2/im inputs, captures the ALU result and CF/ZF/SF/OF, then writes the result back and updates an architectural flag register.
- Sits between the instruction source (fetch/testbench) and the combinational ALU.

Parameters:
RF_DEPTH, 8, number of 8-bit registers (addresses 3 bits; only 8 supported)
RESET_FLAGS, 4'b0000, reset value of {CF,ZF,SF,OF}

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous active-high reset
instr_valid  in  1  instruction word present
instr_ready  out  1  block can accept instruction this cycle
instr  in  16  [15:11] op, [10:8] rd, [7:5] rs, [4:2] im, [1:0] reserved (ignored)
rf_wr_en  in  1  external register load strobe, honoured only in IDLE
rf_wr_addr  in  3  external load address
rf_wr_data  in  8  external load data
alu_op  out  5  opcode to ALU
alu_in1  out  8  R[rd] operand to ALU
alu_in2  out  8  R[rs] operand to ALU
alu_im  out  3  shift/rotate amount to ALU
alu_res  in  8  ALU result
alu_cf, alu_zf, alu_sf, alu_of  in  1 each  ALU flags
flags  out  4  architectural {CF,ZF,SF,OF}
done  out  1  one-cycle pulse, instruction retired
illegal  out  1  one-cycle pulse with done, opcode undefined
show_valid  out  1  one-cycle pulse with done, SHOWR retired
show_data  out  8  captured SHOWR value, held until next SHOWR
dbg_addr  in  3  debug read address
dbg_data  out  8  combinational R[dbg_addr]

Behaviour:
- Reset (sync, highest priority):
  - state=IDLE; all RF entries=0x00; flags=RESET_FLAGS.
  - alu_op/in1/in2/im=0; show_data=0x00; done/illegal/show_valid=0.
  - Reset in any state aborts the instruction in flight: no writeback, no flag update, no pulses.
- FSM states IDLE -> EXEC -> WB -> IDLE; 3 cycles per instruction, no overlap.
- IDLE:
  - instr_ready = !rf_wr_en.
  - If rf_wr_en=1: write R[rf_wr_addr]=rf_wr_data; no instruction is accepted.
  - Else if instr_valid=1: register op/rd/rs/im, capture alu_in1=R[rd] and alu_in2=R[rs], go to EXEC.
- EXEC:
  - instr_ready=0; operand outputs held stable for the full cycle; the ALU evaluates during the clock-low phase.
  - At the rising edge leaving EXEC: capture alu_res and the four alu flags into internal holding registers, then go to WB.
- WB:
  - instr_ready=0; done=1 for exactly this cycle; go to IDLE at the next edge.
  - Commits by opcode:
    - 00001-00101, 01001-01110: R[rd]=captured res; flags=captured flags.
    - 00110 (MOV), 01000 (NOT): R[rd]=captured res; flags unchanged.
    - 11111 (SHOWR): no RF write, flags unchanged; show_data=res; show_valid=1.
    - 00000 (NOP): no RF write, flags unchanged. The ALU's all-ones NOP flags are discarded.
    - Any other opcode: no RF write, flags unchanged; illegal=1.
- Commits become visible on dbg_data/flags the cycle after WB.
- Latency: accept edge k -> done asserted in cycle k+2 -> result visible from cycle k+3.
- rd==rs is legal; operands are captured at accept, so writeback never aliases reads.
- instr_valid outside IDLE is ignored. The source must hold the word until it sees instr_ready=1 and valid=1 on the same edge.
- rf_wr_en outside IDLE is ignored (the load is dropped).
- Register file indices wrap naturally (3-bit). Reserved instruction bits have no effect.

Test Plan:
- Reset, load R1=0x7F, R2=0x01, issue ADD rd=1 rs=2 -> done in cycle k+2; R1=0x80; flags=CF0 ZF0 SF1 OF1 (4'b0011).
- Load R3=0xF0, R4=0x0F, issue AND rd=3 rs=4 -> R3=0x00; flags=4'b0100; instr_ready low for exactly 2 cycles after accept.
- After the AND, issue MOV rd=5 rs=1 -> R5=0x80; flags still 4'b0100.
- Issue SHOWR rd=5 -> show_valid pulse with done; show_data=0x80; no RF change. Issue opcode 10000 -> illegal and done pulse; no RF or flag change.
- Hold instr_valid=1 with rf_wr_en=1 in IDLE -> load occurs, instr_ready=0, instruction accepted only on the next cycle with rf_wr_en=0. The instruction sees the loaded value.
- Accept ADD, assert reset during EXEC -> next cycle state IDLE, RF all 0x00, flags=RESET_FLAGS, no done pulse.
